// File: rtl/instruction_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instruction_encoder_pkg
// Shared RV32I encoder types: abstract opcode selector, register index type,
// major-opcode constants, error codes and the encoder FSM state enum.
// -----------------------------------------------------------------------------
package instruction_encoder_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    // Decoded opcode class as presented by the field producer. Any encoding
    // other than the four supported classes is treated as unknown.
    typedef enum logic [2:0] {
        OPCODE_OP_IMM  = 3'd0,
        OPCODE_OP      = 3'd1,
        OPCODE_LOAD    = 3'd2,
        OPCODE_STORE   = 3'd3,
        OPCODE_UNKNOWN = 3'd7
    } opcode_t;

    typedef logic [4:0] rv_reg_t;

    // 7-bit major opcodes placed in instr[6:0]
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_OPCODE = 2'd1,
        ERR_RANGE  = 2'd2
    } enc_err_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_t;

    // True when imm is representable as a 12-bit signed value: every bit
    // from the sign position of the 12-bit field upward must match.
    function automatic logic imm_fits_12(input logic [XLEN-1:0] imm);
        return (&imm[XLEN-1:11]) || (~|imm[XLEN-1:11]);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// -----------------------------------------------------------------------------
// instruction_encoder_if
// Field-bundle input stream, encoded-word output stream and status signals
// of the instruction encoder.
//   slave  : encoder side (consumes bundles, produces words/status)
//   master : producer/consumer side (drives bundles and out_ready)
// -----------------------------------------------------------------------------
interface instruction_encoder_if #(
    parameter int ADDR_W = 32
);
    import instruction_encoder_pkg::*;

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    opcode_t           in_opcode;
    rv_reg_t           in_rd;
    rv_reg_t           in_rs1;
    rv_reg_t           in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [XLEN-1:0]   in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [ILEN-1:0]   out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic [7:0]        err_count;
    logic              done;

    modport slave (
        input  start, in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr,
               err_pulse, err_code, err_count, done
    );

    modport master (
        output start, in_valid, in_last, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr,
               err_pulse, err_code, err_count, done
    );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// -----------------------------------------------------------------------------
// enc_fifo
// Synchronous FIFO buffering encoded {addr, instr} entries.
// Ports:
//   clk, reset_n       clock / async active-low reset (empties the FIFO)
//   i_push, i_data     write request and entry
//   i_pop              read request (head advances on the clock edge)
//   o_data             head entry, valid while !o_empty
//   o_full, o_empty    occupancy flags
// A push while full is legal only together with a pop; the caller gates it.
// -----------------------------------------------------------------------------
module enc_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only observed once counted in.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// -----------------------------------------------------------------------------
// instruction_encoder
// Streaming RV32I encoder: turns decoded field bundles (OP, OP_IMM, LOAD,
// STORE) into 32-bit instruction words tagged with sequential byte addresses
// for instruction-memory loading. Unsupported opcodes and out-of-range
// immediates are consumed, counted and dropped.
// Ports:
//   clk       clock, all state on rising edge
//   reset_n   asynchronous active-low reset
//   bus       instruction_encoder_if.slave: start, field bundle stream
//             (in_*), encoded word stream (out_*), err_pulse/err_code/
//             err_count status and done pulse
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; bundles not accepted
//   ST_RUN   | accepting bundles until one carrying in_last is consumed
//   ST_DRAIN | no more input; waiting for the output FIFO to empty
//   ST_DONE  | single cycle with done=1, then back to IDLE
// -----------------------------------------------------------------------------
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instruction_encoder_if.slave  bus
);

    enc_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err_pulse;
    enc_err_t          r_err_code;
    logic [7:0]        r_err_count;
    logic              r_done;

    logic [ILEN-1:0]        w_word;
    enc_err_t               w_err;
    logic                   w_shift;
    logic                   w_accept;
    logic                   w_reject;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [ADDR_W+ILEN-1:0] w_rd_data;

    // A full FIFO can still take a word in the cycle its head leaves.
    assign w_pop         = !w_empty && bus.out_ready;
    assign bus.in_ready  = (r_state == ST_RUN) && (!w_full || w_pop);
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_reject      = w_accept && (w_err != ERR_NONE);
    assign w_push        = w_accept && (w_err == ERR_NONE);

    // Encode and range-check the presented bundle.
    always_comb begin
        w_word  = '0;
        w_err   = ERR_NONE;
        w_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);
        case (bus.in_opcode)
            OPCODE_OP: begin
                w_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, OPC_OP};
            end
            OPCODE_OP_IMM: begin
                if (w_shift) begin
                    // Shift amount lives in the rs2 slot; funct7 selects
                    // logical vs arithmetic right shift.
                    w_word = {bus.in_funct7, bus.in_imm[4:0], bus.in_rs1,
                              bus.in_funct3, bus.in_rd, OPC_OP_IMM};
                    if (|bus.in_imm[XLEN-1:5]) begin
                        w_err = ERR_RANGE;
                    end
                end else begin
                    w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                              bus.in_rd, OPC_OP_IMM};
                    if (!imm_fits_12(bus.in_imm)) begin
                        w_err = ERR_RANGE;
                    end
                end
            end
            OPCODE_LOAD: begin
                w_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                          bus.in_rd, OPC_LOAD};
                if (!imm_fits_12(bus.in_imm)) begin
                    w_err = ERR_RANGE;
                end
            end
            OPCODE_STORE: begin
                w_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, bus.in_imm[4:0], OPC_STORE};
                if (!imm_fits_12(bus.in_imm)) begin
                    w_err = ERR_RANGE;
                end
            end
            default: begin
                w_err = ERR_OPCODE;
            end
        endcase
    end

    enc_fifo #(
        .WIDTH (ADDR_W + ILEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  ({r_addr, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= BASE_ADDR;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_err_count <= '0;
            r_done      <= 1'b0;
        end else begin
            r_err_pulse <= w_reject;
            r_done      <= 1'b0;

            if (w_reject) begin
                r_err_code <= w_err;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end

            // Addresses advance only for words actually written; wrap is silent.
            if (w_push) begin
                r_addr <= r_addr + ADDR_W'(4);
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_RUN;
                        r_addr      <= BASE_ADDR;
                        r_err_code  <= ERR_NONE;
                        r_err_count <= '0;
                    end
                end
                ST_RUN: begin
                    // A rejected bundle carrying in_last still ends the program.
                    if (w_accept && bus.in_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_rd_data[ILEN-1:0];
    assign bus.out_addr  = w_rd_data[ADDR_W+ILEN-1:ILEN];
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_code  = r_err_code;
    assign bus.err_count = r_err_count;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    localparam int          AW    = 32;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_encoder_if #(.ADDR_W(AW)) bus();

    instruction_encoder #(
        .ADDR_W     (AW),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    exp_t        q[$];
    bit          m_run;
    logic [31:0] m_addr;
    logic [1:0]  m_code;
    int          m_count;
    bit          m_pulse;

    int  total = 0;
    int  passed = 0;
    int  done_seen = 0;
    bit  accepted;
    int  ready_mode = 0;
    int  hold_cnt = 0;
    bit  lit_en = 0;
    logic [31:0] lit_w;
    int  lit_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoding from field weights (powers of two) with plain arithmetic.
    function automatic void model_enc(input opcode_t op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm,
                                      output logic [31:0] w, output int err);
        longint s, v, base;
        s    = longint'($signed(imm));
        base = longint'(rs1) * 32768 + longint'(f3) * 4096 + longint'(rd) * 128;
        v    = 0;
        err  = 0;
        case (op)
            OPCODE_OP:
                v = longint'(f7) * 33554432 + longint'(rs2) * 1048576 + base + 51;
            OPCODE_OP_IMM: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (s < 0 || s > 31) err = 2;
                    v = longint'(f7) * 33554432 + (s & 31) * 1048576 + base + 19;
                end else begin
                    if (s < -2048 || s > 2047) err = 2;
                    v = (s & 4095) * 1048576 + base + 19;
                end
            end
            OPCODE_LOAD: begin
                if (s < -2048 || s > 2047) err = 2;
                v = (s & 4095) * 1048576 + base + 3;
            end
            OPCODE_STORE: begin
                if (s < -2048 || s > 2047) err = 2;
                v = ((s >>> 5) & 127) * 33554432 + longint'(rs2) * 1048576
                    + longint'(rs1) * 32768 + longint'(f3) * 4096 + (s & 31) * 128 + 35;
            end
            default: err = 1;
        endcase
        w = v[31:0];
    endfunction

    // One clock: choose out_ready, sample and compare, update model, advance.
    task automatic step();
        exp_t        e;
        logic [31:0] w;
        int          err;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (hold_cnt > 0) begin
                    bus.out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        endcase
        #1;
        check("in_ready", bus.in_ready,
              m_run && (q.size() < DEPTH || (q.size() > 0 && bus.out_ready)));
        check("out_valid", bus.out_valid, q.size() != 0);
        check("err_pulse", bus.err_pulse, m_pulse);
        check("err_code", bus.err_code, m_code);
        check("err_count", bus.err_count, m_count);
        if (bus.done) done_seen++;
        if (bus.out_valid && q.size() > 0) begin
            check("out_instr", bus.out_instr, q[0].w);
            check("out_addr", bus.out_addr, q[0].a);
            if (bus.out_ready) void'(q.pop_front());
        end
        m_pulse = 0;
        if (bus.in_valid && bus.in_ready) begin
            accepted = 1;
            model_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                      bus.in_funct3, bus.in_funct7, bus.in_imm, w, err);
            if (lit_en) begin
                w   = lit_w;
                err = lit_err;
            end
            if (err == 0) begin
                e.w = w;
                e.a = m_addr;
                q.push_back(e);
                m_addr = m_addr + 32'd4;
            end else begin
                m_pulse = 1;
                m_code  = 2'(err);
                if (m_count < 255) m_count++;
            end
            if (bus.in_last) m_run = 0;
        end
        if (bus.start) begin
            m_run   = 1;
            m_addr  = BASE;
            m_code  = 0;
            m_count = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input opcode_t op, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input logic [31:0] imm,
                        input bit last, input bit use_lit,
                        input logic [31:0] lw, input int le);
        bus.in_opcode = op;
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_funct3 = 3'(f3);
        bus.in_funct7 = 7'(f7);
        bus.in_imm    = imm;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        lit_en  = use_lit;
        lit_w   = lw;
        lit_err = le;
        accepted = 0;
        for (int i = 0; i < 200 && !accepted; i++) step();
        if (!accepted) check("accept_timeout", accepted, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lit_en       = 0;
    endtask

    task automatic wait_done(input int max);
        int d0;
        int n;
        d0 = done_seen;
        n  = 0;
        while (done_seen == d0 && n < max) begin
            step();
            n++;
        end
        step();
        check("done_pulse", done_seen - d0, 1);
    endtask

    initial begin
        int          d0;
        int          r;
        opcode_t     op;
        logic [31:0] imm;
        logic [31:0] edge_imm [8];

        edge_imm[0] = 32'd2047;  edge_imm[1] = 32'd2048;
        edge_imm[2] = 32'hFFFF_F800; edge_imm[3] = 32'hFFFF_F7FF;
        edge_imm[4] = 32'd31;    edge_imm[5] = 32'd32;
        edge_imm[6] = 32'd0;     edge_imm[7] = 32'hFFFF_FFFF;

        bus.start = 0; bus.in_valid = 0; bus.in_last = 0; bus.in_opcode = OPCODE_OP;
        bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_funct3 = 0;
        bus.in_funct7 = 0; bus.in_imm = 0; bus.out_ready = 1;
        m_run = 0; m_addr = BASE; m_code = 0; m_count = 0; m_pulse = 0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_err_code", bus.err_code, 0);
        check("rst_err_count", bus.err_count, 0);
        check("rst_done", bus.done, 0);
        reset_n = 1'b1;
        step();

        // Program 1: addi, add, sw, lw; addresses wrap past 2^32
        ready_mode = 0;
        do_start();
        send(OPCODE_OP_IMM, 1, 2, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 32'hFFF10093, 0);
        send(OPCODE_OP, 3, 1, 2, 0, 0, 32'd0, 0, 1, 32'h002081B3, 0);
        send(OPCODE_STORE, 0, 10, 5, 2, 0, 32'd8, 0, 1, 32'h00552423, 0);
        send(OPCODE_LOAD, 4, 6, 0, 2, 0, 32'hFFFF_FFFC, 1, 1, 32'hFFC32203, 0);
        wait_done(50);

        // Program 2: shifts, unknown opcode, out-of-range shift, rejected last
        do_start();
        send(OPCODE_OP_IMM, 1, 1, 0, 5, 32, 32'd3, 0, 1, 32'h4030D093, 0);
        send(OPCODE_UNKNOWN, 1, 1, 1, 0, 0, 32'd0, 0, 1, 32'd0, 1);
        send(OPCODE_OP_IMM, 1, 1, 0, 5, 32, 32'd32, 0, 1, 32'd0, 2);
        send(OPCODE_OP, 3, 1, 2, 0, 0, 32'd0, 0, 1, 32'h002081B3, 0);
        send(opcode_t'(3'd5), 0, 0, 0, 0, 0, 32'd0, 1, 1, 32'd0, 1);
        wait_done(50);

        // Program 3: 300 rejected bundles saturate the error counter
        do_start();
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(4, 7);
            send(opcode_t'(3'(r)), 0, 0, 0, 0, 0, 32'd0, i == 299, 0, 32'd0, 0);
        end
        wait_done(50);
        check("err_sat", bus.err_count, 255);

        // Program 4: consumer stalls 10 cycles while 5 bundles are offered
        ready_mode = 2;
        hold_cnt   = 10;
        do_start();
        for (int i = 0; i < 5; i++) begin
            send(OPCODE_OP, i + 1, i + 2, i + 3, i % 8, 0, 32'd0, i == 4, 0, 32'd0, 0);
        end
        wait_done(50);

        // Program 5: randomized fields, gaps and backpressure
        ready_mode = 1;
        do_start();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8) op = opcode_t'(3'(r % 4));
            else       op = opcode_t'(3'(r == 8 ? 7 : 5));
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 80)) - 32'd40;
                1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                2: imm = $urandom;
                default: imm = edge_imm[$urandom_range(0, 7)];
            endcase
            repeat ($urandom_range(0, 2)) step();
            send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 7), $urandom_range(0, 127), imm, i == 79, 0, 32'd0, 0);
        end
        wait_done(500);

        // Reset while draining two buffered words
        ready_mode = 2;
        hold_cnt   = 1000;
        do_start();
        send(OPCODE_OP, 7, 8, 9, 0, 0, 32'd0, 0, 0, 32'd0, 0);
        send(OPCODE_OP, 7, 8, 9, 0, 32, 32'd0, 1, 0, 32'd0, 0);
        step();
        step();
        d0 = done_seen;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_done", bus.done, 0);
        q.delete();
        m_run = 0; m_pulse = 0; m_code = 0; m_count = 0; m_addr = BASE;
        @(negedge clk);
        @(negedge clk);
        reset_n    = 1'b1;
        ready_mode = 0;
        hold_cnt   = 0;
        repeat (20) step();
        check("no_done_after_reset", done_seen - d0, 0);
        do_start();
        send(OPCODE_OP, 3, 1, 2, 0, 0, 32'd0, 1, 1, 32'h002081B3, 0);
        wait_done(50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
